// File: rtl/fetch_control_pkg.sv
// rtl/fetch_control_pkg.sv - shared types and constants for the fetch-stage controller
package fetch_control_pkg;

    typedef enum logic {
        FC_RUN     = 1'b0,
        FC_PENDING = 1'b1
    } fc_state_t;

    localparam logic [31:0] PC_INCR   = 32'd4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Instruction fetches are word aligned; low two address bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_control_ifid_register.sv
// rtl/fetch_control_ifid_register.sv - IF/ID pipeline register with hold and bubble insertion
import fetch_control_pkg::*;

module ifid_register #(
    parameter logic [31:0] BUBBLE_INSTR = NOP_INSTR
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] instr,
    input  logic [31:0] pcplus4,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pcplus4,
    output logic        ifid_valid
);

    // Hold on stall, capture fetched word on load, replace with bubble on squash.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ifid_instr   <= BUBBLE_INSTR;
            ifid_pcplus4 <= 32'd0;
            ifid_valid   <= 1'b0;
        end else if (load) begin
            if (bubble) begin
                ifid_instr   <= BUBBLE_INSTR;
                ifid_pcplus4 <= 32'd0;
                ifid_valid   <= 1'b0;
            end else begin
                ifid_instr   <= instr;
                ifid_pcplus4 <= pcplus4;
                ifid_valid   <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_control.sv
// rtl/fetch_control.sv - next-PC selection, stall-time redirect buffering and squash control
import fetch_control_pkg::*;

module fetch_control #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] PCResult,
    input  logic [31:0] Instruction,
    input  logic        StallReq,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        JumpTaken,
    input  logic [31:0] JumpTarget,
    output logic [31:0] Address,
    output logic        write,
    output logic [31:0] IFID_Instruction,
    output logic [31:0] IFID_PCPlus4,
    output logic        IFID_Valid,
    output logic        Misaligned,
    output logic [15:0] FlushCount
);

    fc_state_t   state;
    fc_state_t   state_next;
    logic [31:0] pend_target;
    logic        pend_misaligned;

    logic        redir;
    logic [31:0] redir_target;
    logic [31:0] pc_plus4;
    logic        apply;
    logic        apply_misaligned;
    logic        pend_load;

    // The branch resolves in EX, so it belongs to an older instruction than an ID jump.
    assign redir        = BranchTaken | JumpTaken;
    assign redir_target = BranchTaken ? BranchTarget : JumpTarget;
    assign pc_plus4     = PCResult + PC_INCR;

    // Next-PC mux and FSM transitions; Reset suppresses every PC write.
    always_comb begin
        state_next       = state;
        write            = 1'b0;
        Address          = pc_plus4;
        apply            = 1'b0;
        apply_misaligned = 1'b0;
        pend_load        = 1'b0;
        if (Reset) begin
            Address = RESET_PC;
        end else begin
            case (state)
                FC_RUN: begin
                    if (!StallReq) begin
                        write = 1'b1;
                        if (redir) begin
                            Address          = word_align(redir_target);
                            apply            = 1'b1;
                            apply_misaligned = |redir_target[1:0];
                        end
                    end else if (redir) begin
                        pend_load  = 1'b1;
                        state_next = FC_PENDING;
                    end
                end
                FC_PENDING: begin
                    // Redirects seen here come from wrong-path instructions.
                    if (!StallReq) begin
                        write            = 1'b1;
                        Address          = pend_target;
                        apply            = 1'b1;
                        apply_misaligned = pend_misaligned;
                        state_next       = FC_RUN;
                    end
                end
                default: state_next = FC_RUN;
            endcase
        end
    end

    // State, buffered redirect, misalignment pulse and saturating squash counter.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state           <= FC_RUN;
            pend_target     <= 32'd0;
            pend_misaligned <= 1'b0;
            Misaligned      <= 1'b0;
            FlushCount      <= 16'd0;
        end else begin
            state      <= state_next;
            Misaligned <= apply_misaligned;
            if (pend_load) begin
                pend_target     <= word_align(redir_target);
                pend_misaligned <= |redir_target[1:0];
            end
            if (apply && (FlushCount != 16'hFFFF)) begin
                FlushCount <= FlushCount + 16'd1;
            end
        end
    end

    ifid_register #(
        .BUBBLE_INSTR (NOP)
    ) u_ifid (
        .Clk          (Clk),
        .Reset        (Reset),
        .load         (write),
        .bubble       (apply),
        .instr        (Instruction),
        .pcplus4      (pc_plus4),
        .ifid_instr   (IFID_Instruction),
        .ifid_pcplus4 (IFID_PCPlus4),
        .ifid_valid   (IFID_Valid)
    );

endmodule

// File: tb/tb_fetch_control.sv
// tb/tb_fetch_control.sv - scoreboard bench for fetch_control
module tb_fetch_control;

    logic        Clk;
    logic        Reset;
    logic [31:0] PCResult;
    logic [31:0] Instruction;
    logic        StallReq;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        JumpTaken;
    logic [31:0] JumpTarget;
    logic [31:0] Address;
    logic        write;
    logic [31:0] IFID_Instruction;
    logic [31:0] IFID_PCPlus4;
    logic        IFID_Valid;
    logic        Misaligned;
    logic [15:0] FlushCount;

    fetch_control #(
        .RESET_PC (32'h0),
        .NOP      (32'h0)
    ) dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .PCResult         (PCResult),
        .Instruction      (Instruction),
        .StallReq         (StallReq),
        .BranchTaken      (BranchTaken),
        .BranchTarget     (BranchTarget),
        .JumpTaken        (JumpTaken),
        .JumpTarget       (JumpTarget),
        .Address          (Address),
        .write            (write),
        .IFID_Instruction (IFID_Instruction),
        .IFID_PCPlus4     (IFID_PCPlus4),
        .IFID_Valid       (IFID_Valid),
        .Misaligned       (Misaligned),
        .FlushCount       (FlushCount)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        mis;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic        m_pending;
    logic [31:0] m_pend;
    logic        m_pend_mis;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic        m_mis;
    logic [15:0] m_cnt;
    logic [31:0] pc;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, check combinational outputs, push registered expectations,
    // clock, then pop and compare the registered outputs.
    task automatic step(input logic rst, input logic stall,
                        input logic br, input logic [31:0] bt,
                        input logic jp, input logic [31:0] jt);
        logic        e_write;
        logic [31:0] e_addr;
        logic [31:0] tgt;
        logic        apply;
        logic        amis;
        exp_t        e;
        exp_t        o;
        Reset        = rst;
        StallReq     = stall;
        BranchTaken  = br;
        BranchTarget = bt;
        JumpTaken    = jp;
        JumpTarget   = jt;
        PCResult     = pc;
        Instruction  = pc ^ 32'h1357_9BDF;
        #1;
        tgt     = br ? bt : jt;
        e_write = 1'b0;
        e_addr  = pc + 32'd4;
        apply   = 1'b0;
        amis    = 1'b0;
        if (rst) begin
            m_pending = 1'b0; m_pend = 32'd0; m_pend_mis = 1'b0;
            m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0; m_mis = 1'b0; m_cnt = 16'd0;
        end else begin
            if (!m_pending) begin
                if (!stall) begin
                    e_write = 1'b1;
                    if (br || jp) begin
                        e_addr = tgt & 32'hFFFF_FFFC;
                        apply  = 1'b1;
                        amis   = (tgt[1:0] != 2'b00);
                    end
                end else if (br || jp) begin
                    m_pending  = 1'b1;
                    m_pend     = tgt & 32'hFFFF_FFFC;
                    m_pend_mis = (tgt[1:0] != 2'b00);
                end
            end else if (!stall) begin
                e_write   = 1'b1;
                e_addr    = m_pend;
                apply     = 1'b1;
                amis      = m_pend_mis;
                m_pending = 1'b0;
            end
            if (e_write) begin
                if (apply) begin
                    m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
                    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                end else begin
                    m_instr = pc ^ 32'h1357_9BDF; m_pc4 = pc + 32'd4; m_valid = 1'b1;
                end
            end
            m_mis = amis;
        end
        check("write", {31'd0, write}, {31'd0, e_write});
        if (e_write) check("Address", Address, e_addr);
        e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid; e.mis = m_mis; e.cnt = m_cnt;
        exp_q.push_back(e);
        @(posedge Clk);
        #1;
        if (rst) pc = 32'd0;
        else if (e_write) pc = e_addr;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            o = exp_q.pop_front();
            check("IFID_Instruction", IFID_Instruction, o.instr);
            check("IFID_PCPlus4", IFID_PCPlus4, o.pc4);
            check("IFID_Valid", {31'd0, IFID_Valid}, {31'd0, o.valid});
            check("Misaligned", {31'd0, Misaligned}, {31'd0, o.mis});
            check("FlushCount", {16'd0, FlushCount}, {16'd0, o.cnt});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    initial begin
        pc = 32'd0;
        m_pending = 1'b0; m_pend = 32'd0; m_pend_mis = 1'b0;
        m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0; m_mis = 1'b0; m_cnt = 16'd0;

        // Reset then sequential run: 4, 8, 12
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        idle(3);
        check("pc_after_run", pc, 32'd12);

        // Taken branch from 0x20
        pc = 32'h20;
        step(1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 32'd0);
        idle(2);

        // Jump during a 3-cycle stall, then release
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h200);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        check("pc_after_pending", pc, 32'h200);
        idle(1);

        // Branch beats jump in the same cycle
        step(1'b0, 1'b0, 1'b1, 32'h300, 1'b1, 32'h400);
        check("branch_priority", pc, 32'h300);
        idle(1);

        // Wrap at top of address space, then misaligned branch target
        pc = 32'hFFFF_FFFC;
        idle(1);
        check("wrap", pc, 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'h103, 1'b0, 32'd0);
        idle(2);

        // Stalled redirect, wrong-path redirects ignored while pending and on release
        step(1'b0, 1'b1, 1'b1, 32'h701, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h800);
        step(1'b0, 1'b0, 1'b1, 32'h900, 1'b0, 32'd0);
        check("pending_target", pc, 32'h700);
        idle(1);

        // Reset while a target is buffered
        step(1'b0, 1'b1, 1'b1, 32'h500, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        check("no_stale_pending", pc, 32'd4);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_control.md
# fetch_control

Fetch-stage controller that drives the program counter's `Address` and `write` inputs and owns the IF/ID pipeline register. Each cycle it picks the next PC from sequential increment, branch/jump redirects, or a redirect buffered during a stall. It also squashes wrong-path fetches. It sits between the program counter, instruction memory, hazard unit and EX-stage branch resolution.

## Interface
- `RESET_PC`, 32'h0000_0000: documentation only; must match the program counter's reset value.
- `NOP`, 32'h0000_0000: instruction word inserted as a bubble.
- `Clk`  input  1  clock, rising edge.
- `Reset`  input  1  reset, synchronous, active-high.
- `PCResult`  input  32  current PC from the program counter.
- `Instruction`  input  32  instruction memory read data at `PCResult`, combinational.
- `StallReq`  input  1  hazard unit stall request for IF and ID.
- `BranchTaken`  input  1  EX-stage branch resolved taken.
- `BranchTarget`  input  32  branch target.
- `JumpTaken`  input  1  ID-stage jump.
- `JumpTarget`  input  32  jump target.
- `Address`  output  32  next PC to the program counter.
- `write`  output  1  PC write enable.
- `IFID_Instruction`  output  32  registered instruction.
- `IFID_PCPlus4`  output  32  registered `PCResult + 4`.
- `IFID_Valid`  output  1  0 means bubble.
- `Misaligned`  output  1  registered; pulses when an applied target had bits [1:0] ≠ 0.
- `FlushCount`  output  16  saturating count of squashes.

## Operation
- **States:** `RUN`, `PENDING`. State holds the buffered target `PendTarget` (32 bits).
- **Redirect selection:** `Redir = BranchTaken | JumpTaken`. If both are asserted, the branch wins because it is the older instruction. `RedirTarget` is the selected target.
- **RUN, no stall, no Redir:**
  - `write`=1, `Address`=`PCResult + 4`, with modulo 2^32 wrap.
  - IF/ID loads `Instruction`, `PCResult + 4`, `Valid`=1.
- **RUN, no stall, Redir:**
  - `write`=1, `Address`={`RedirTarget[31:2]`, 2'b00}.
  - IF/ID loads `NOP`, `PCPlus4`=0, `Valid`=0.
  - `FlushCount` increments.
- **RUN, stall, no Redir:** `write`=0, IF/ID holds, `Address`=`PCResult + 4` (don't-care).
- **RUN, stall, Redir:**
  - `write`=0 and IF/ID holds.
  - `PendTarget` ← aligned `RedirTarget`; the `Misaligned` check is deferred until the target is applied.
  - Go to `PENDING`.
- **PENDING, stall:** `write`=0, IF/ID holds. A new Redir is ignored because it is wrong-path.
- **PENDING, no stall:**
  - `write`=1, `Address`=`PendTarget`, IF/ID loads a bubble.
  - `FlushCount` increments. Go to `RUN`.
  - Any Redir in this cycle is ignored.
- **Misaligned:** set for one cycle after any cycle that applied a target with bits [1:0] ≠ 0; otherwise 0.
- **FlushCount:** saturates at 16'hFFFF and never wraps.

## Timing
- `Address` and `write` are combinational from the inputs and state. The new PC appears in `PCResult` one clock after `write`=1.
- IF/ID outputs are registered, so one cycle of latency from `PCResult`/`Instruction`.
- A redirect seen in cycle N makes `PCResult` = target in N+1. The IF/ID bubble is visible in N+1, and the target instruction is in IF/ID in N+2.
- **Reset (synchronous, overrides everything, including mid-`PENDING`):**
  - `write` is forced to 0 during `Reset`.
  - State → `RUN`, `PendTarget` → 0, `IFID_Instruction` → `NOP`.
  - `IFID_PCPlus4` → 0, `IFID_Valid` → 0, `Misaligned` → 0, `FlushCount` → 0.
- On the first cycle after `Reset` deasserts, normal `RUN` behaviour applies.

## Structure
- Shared package holds:
  - state encoding: `FC_RUN`=1'b0, `FC_PENDING`=1'b1;
  - `PC_INCR`=32'd4;
  - `NOP_INSTR`=32'h0.
- Sub-module `ifid_register`:
  - inputs: `Clk`, `Reset`, `load`, `bubble`, `instr`, `pcplus4`;
  - behaviour: hold when `load`=0, bubble overrides the data.
- Next-PC mux, FSM and counter stay in `fetch_control`.

## Test plan
- **Reset then run:**
  - stimulus: `Reset` 2 cycles, release, `PCResult` follows `Address`;
  - response: `Address` sequence 4, 8, 12; `IFID_Valid`=1 from the second cycle after release.
- **Taken branch:**
  - stimulus: `PCResult`=0x20, `BranchTaken`=1, `BranchTarget`=0x100;
  - response: `write`=1, `Address`=0x100; next cycle `IFID_Valid`=0, `FlushCount`=1.
- **Redirect during stall:**
  - stimulus: `StallReq`=1 with `JumpTaken` to 0x200 for 3 cycles, then `StallReq`=0;
  - response: `write`=0 for 3 cycles; the release cycle has `Address`=0x200, `write`=1.
- **Branch and jump same cycle:**
  - stimulus: branch 0x300, jump 0x400;
  - response: `Address`=0x300.
- **Wrap and misalignment:**
  - stimulus: `PCResult`=0xFFFF_FFFC gives `Address`=0; `BranchTarget`=0x103 applied;
  - response: `Address`=0x100 and `Misaligned`=1 for exactly one cycle.
- **Reset mid-PENDING:**
  - stimulus: buffered target 0x500, assert `Reset`, then release with `StallReq`=0;
  - response: `Address`=`PCResult + 4`, not 0x500; `FlushCount`=0.
